// File: rtl/dip_sw_event_ctrl_if.sv
// Slave register bus for the DIP switch event controller.
//   address    : register select (0 state, 1 irqmask, 2 edgecapture, 3 raw)
//   chipselect : access qualifier
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data, one cycle after the address is presented
//   irq        : registered level interrupt
interface dip_sw_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/dip_sw_event_ctrl.sv
// DIP switch debouncer with edge capture and a masked level interrupt.
// Each switch is synchronized, sampled on a prescaler tick, and only accepted
// after STABLE_TICKS consecutive ticks that disagree with the debounced state.
// Every accepted change (either direction) sets a sticky edgecapture bit.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   in_port  : raw asynchronous switch levels
//   bus      : register slave (address/chipselect/write_n/writedata/readdata/irq)
module dip_sw_event_ctrl #(
  parameter int WIDTH        = 3,
  parameter int TICK_CYCLES  = 50000,
  parameter int STABLE_TICKS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  dip_sw_event_ctrl_if.slave bus
);
  localparam int              PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [3:0]      STABLE_N  = 4'(STABLE_TICKS);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] deb_q, deb_d, chg;
  logic [WIDTH-1:0] ecap_q, ecap_d, mask_q, mask_d, clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr;

  // Prescaler: tick is high on the wrap cycle only.
  assign tick    = (presc_q == TICK_LAST);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Per-switch stability counter; the accepting tick updates the debounced
  // bit and reports a change in the same cycle so edgecapture lines up.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [3:0] cnt_q, cnt_d;
    logic       deb_n, chg_n;

    always_comb begin
      cnt_d = cnt_q;
      deb_n = deb_q[i];
      chg_n = 1'b0;
      if (tick) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q + 4'd1 == STABLE_N) begin
            cnt_d = '0;
            deb_n = sync2_q[i];
            chg_n = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

    assign deb_d[i] = deb_n;
    assign chg[i]   = chg_n;
  end

  assign wr     = bus.chipselect & ~bus.write_n;
  assign clr    = (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
  // Set is OR'd in after the clear so a same-cycle change wins.
  assign ecap_d = (ecap_q & ~clr) | chg;
  assign mask_d = (wr && bus.address == 2'd1) ? bus.writedata[WIDTH-1:0] : mask_q;
  assign irq_d  = |(ecap_q & mask_q);

  // Read mux runs every cycle regardless of chipselect; reads never alter state.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      2'd0:    rdata_d[WIDTH-1:0] = deb_q;
      2'd1:    rdata_d[WIDTH-1:0] = mask_q;
      2'd2:    rdata_d[WIDTH-1:0] = ecap_q;
      default: rdata_d[WIDTH-1:0] = sync2_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      deb_q   <= '0;
      ecap_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      deb_q   <= deb_d;
      ecap_q  <= ecap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = irq_q;

  // Write data above WIDTH has no storage behind it.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;
endmodule

// File: tb/tb_dip_sw_event_ctrl.sv
module tb_dip_sw_event_ctrl;
  localparam int W  = 3;
  localparam int TC = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  int           tests = 0;
  int           fails = 0;

  dip_sw_event_ctrl_if bus();

  dip_sw_event_ctrl #(.WIDTH(W), .TICK_CYCLES(TC), .STABLE_TICKS(ST)) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the switch level seen after the synchronizer delay,
  // the tick schedule as cycles-since-reset modulo TC, and for each switch the
  // length of the current run of ticks that disagreed with the accepted level.
  logic [W-1:0] seen1 = '0, seen2 = '0;
  int           ncyc = 0;
  int           run [W];
  logic [W-1:0] m_deb = '0, m_ecap = '0, m_mask = '0;
  logic [31:0]  m_rd = '0;
  logic         m_irq = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic will_change(input int b);
    return ((ncyc % TC) == TC - 1) && (seen2[b] != m_deb[b]) && (run[b] == ST - 1);
  endfunction

  task automatic model_edge();
    logic [W-1:0] chg, clr, nd;
    logic [31:0]  rd;
    logic         wrt;
    if (!reset_n) begin
      seen1 = '0; seen2 = '0; ncyc = 0;
      for (int b = 0; b < W; b++) run[b] = 0;
      m_deb = '0; m_ecap = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
      return;
    end
    chg = '0;
    nd  = m_deb;
    if ((ncyc % TC) == TC - 1) begin
      for (int b = 0; b < W; b++) begin
        if (seen2[b] != m_deb[b]) begin
          run[b]++;
          if (run[b] == ST) begin
            run[b] = 0;
            nd[b]  = seen2[b];
            chg[b] = 1'b1;
          end
        end else begin
          run[b] = 0;
        end
      end
    end
    wrt = bus.chipselect && !bus.write_n;
    rd  = '0;
    case (bus.address)
      2'd0:    rd[W-1:0] = m_deb;
      2'd1:    rd[W-1:0] = m_mask;
      2'd2:    rd[W-1:0] = m_ecap;
      default: rd[W-1:0] = seen2;
    endcase
    clr    = (wrt && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
    m_irq  = |(m_ecap & m_mask);
    m_ecap = (m_ecap & ~clr) | chg;
    if (wrt && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
    m_rd  = rd;
    m_deb = nd;
    seen2 = seen1;
    seen1 = in_port;
    ncyc++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("readdata", bus.readdata, m_rd);
      check("irq", {31'b0, bus.irq}, {31'b0, m_irq});
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    step(1);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  initial begin
    logic found;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    for (int b = 0; b < W; b++) run[b] = 0;

    // Power-up with switches 0 and 2 already on.
    in_port = 3'b101;
    step(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    step(16);
    check("pwrup_state", bus.readdata, 32'h5);
    bus.address = 2'd2;
    step(1);
    check("pwrup_edgecap", bus.readdata, 32'h5);
    check("pwrup_irq", {31'b0, bus.irq}, 32'h0);
    bus_wr(2'd2, 32'h7);
    step(2);
    check("w1c_all", bus.readdata, 32'h0);

    // Short glitch on switch 1.
    bus.address = 2'd0;
    in_port = 3'b111;
    step(6);
    in_port = 3'b101;
    step(12);
    check("glitch_state", bus.readdata, 32'h5);
    bus.address = 2'd2;
    step(1);
    check("glitch_edgecap", bus.readdata, 32'h0);

    // Interrupt path on switch 1.
    bus_wr(2'd1, 32'h2);
    bus.address = 2'd2;
    in_port = 3'b111;
    step(20);
    check("irq_edgecap", bus.readdata, 32'h2);
    check("irq_set", {31'b0, bus.irq}, 32'h1);
    bus_wr(2'd2, 32'h2);
    step(1);
    check("irq_cleared", {31'b0, bus.irq}, 32'h0);

    // Clear lands on the same edge as switch 1 falling back.
    in_port = 3'b101;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (will_change(1)) begin
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h2;
        found = 1'b1;
      end
      step(1);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
    end
    step(1);
    check("collide_reached", {31'b0, found}, 32'h1);
    check("collide_set_wins", bus.readdata, 32'h2);

    // Reset while switch 0 has two disagreeing ticks pending.
    bus.address = 2'd0;
    in_port = 3'b100;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (run[0] == 2) found = 1'b1;
      else step(1);
    end
    check("pend_reached", {31'b0, found}, 32'h1);
    reset_n = 1'b0;
    in_port = 3'b001;
    #1;
    check("mid_rst_readdata", bus.readdata, 32'h0);
    step(3);
    check("mid_rst_hold", bus.readdata, 32'h0);
    reset_n = 1'b1;
    step(12);
    check("full_3_ticks_pending", bus.readdata, 32'h0);
    step(4);
    check("full_3_ticks_done", bus.readdata, 32'h1);
    check("irq_masked_after_rst", {31'b0, bus.irq}, 32'h0);

    // Mask readback and ignored writes to read-only registers.
    bus_wr(2'd1, 32'hFFFF_FFFF);
    bus.address = 2'd1;
    step(1);
    check("mask_readback", bus.readdata, 32'h7);
    bus_wr(2'd0, 32'hFFFF_FFFF);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus.address = 2'd0;
    step(1);
    check("ro_write_ignored", bus.readdata, 32'h1);
    bus.address = 2'd3;
    step(1);
    check("raw_readback", bus.readdata, 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) in_port = 3'($urandom);
      bus.address    = 2'($urandom);
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n    = ($urandom_range(0, 3) != 0);
      bus.writedata  = $urandom;
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
